// File: rtl/fifo_ptr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_ptr_pkg                                                               |
// | Shared async-FIFO pointer constants and Gray/binary conversion helpers.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fifo_ptr_pkg;

  localparam int FIFO_ADDR_W      = 4;
  localparam int FIFO_SYNC_STAGES = 2;

  // Zero-extended operands convert identically, so callers of any width up
  // to 32 bits pass a widened value and truncate the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_ndff.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_ndff                                                                  |
// | Multi-flop clock-domain synchronizer, asynchronous active-low reset.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module sync_ndff #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/fifo_rd_ptr_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_rd_ptr_sync                                                           |
// | Async FIFO read-side pointer stage: synchronizes the write Gray pointer,  |
// | keeps the read pointer and produces registered empty/level status.        |
// | Optional checks (sticky Gray-step error, underflow): FIFO_PTR_CHK_EN.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fifo_rd_ptr_sync
  import fifo_ptr_pkg::*;
#(
  parameter int ADDR_W      = FIFO_ADDR_W,
  parameter int SYNC_STAGES = FIFO_SYNC_STAGES
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [ADDR_W:0] wr_gray_i,
  input  logic            rd_en_i,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W:0] rd_ptr_o,
  output logic [ADDR_W:0] rd_gray_o,
  output logic [ADDR_W:0] wr_ptr_sync_o,
  output logic            empty_o,
  output logic [ADDR_W:0] level_o,
  output logic            gray_err_o,
  output logic            underflow_o
);

  localparam int PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] wr_gray_sync;
  logic [PTR_W-1:0] wr_bin;
  logic             accept;
  logic [PTR_W-1:0] rd_ptr_d,  rd_ptr_q;
  logic [PTR_W-1:0] rd_gray_d, rd_gray_q;
  logic [PTR_W-1:0] wr_sync_q;
  logic             empty_d,   empty_q;
  logic [PTR_W-1:0] level_d,   level_q;

  sync_ndff #(
    .WIDTH  (PTR_W),
    .STAGES (SYNC_STAGES)
  ) u_wr_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (wr_gray_i),
    .q_o     (wr_gray_sync)
  );

  assign wr_bin = PTR_W'(gray2bin(32'(wr_gray_sync)));

  // Status is computed from the post-read pointer so empty asserts on the
  // same edge as the final read.
  always_comb begin
    accept    = rd_en_i && !empty_q;
    rd_ptr_d  = rd_ptr_q + PTR_W'(accept);
    rd_gray_d = PTR_W'(bin2gray(32'(rd_ptr_d)));
    empty_d   = (rd_ptr_d == wr_bin);
    level_d   = wr_bin - rd_ptr_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q  <= '0;
      rd_gray_q <= '0;
      wr_sync_q <= '0;
      empty_q   <= 1'b1;
      level_q   <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      rd_gray_q <= rd_gray_d;
      wr_sync_q <= wr_bin;
      empty_q   <= empty_d;
      level_q   <= level_d;
    end
  end

  assign rd_ptr_o      = rd_ptr_q;
  assign rd_addr_o     = rd_ptr_q[ADDR_W-1:0];
  assign rd_gray_o     = rd_gray_q;
  assign wr_ptr_sync_o = wr_sync_q;
  assign empty_o       = empty_q;
  assign level_o       = level_q;

`ifdef FIFO_PTR_CHK_EN
  logic [PTR_W-1:0] gray_prev_q;
  logic             gray_err_d,  gray_err_q;
  logic             underflow_d, underflow_q;

  // A legal Gray pointer moves at most one bit between samples.
  always_comb begin
    gray_err_d  = gray_err_q  | ($countones(wr_gray_sync ^ gray_prev_q) > 1);
    underflow_d = underflow_q | (rd_en_i & empty_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gray_prev_q <= '0;
      gray_err_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      gray_prev_q <= wr_gray_sync;
      gray_err_q  <= gray_err_d;
      underflow_q <= underflow_d;
    end
  end

  assign gray_err_o  = gray_err_q;
  assign underflow_o = underflow_q;
`else
  assign gray_err_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_ptr_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_rd_ptr_sync                                                        |
// | Self-checking bench: hand vector table plus model-fed scoreboard.         |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_fifo_rd_ptr_sync;

  localparam int AW = 4;
  localparam int PW = AW + 1;
  localparam int SS = 2;
`ifdef FIFO_PTR_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [PW-1:0] wr_gray_i;
  logic          rd_en_i;
  logic [AW-1:0] rd_addr_o;
  logic [PW-1:0] rd_ptr_o, rd_gray_o, wr_ptr_sync_o, level_o;
  logic          empty_o, gray_err_o, underflow_o;

  fifo_rd_ptr_sync #(.ADDR_W(AW), .SYNC_STAGES(SS)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .wr_gray_i     (wr_gray_i),
    .rd_en_i       (rd_en_i),
    .rd_addr_o     (rd_addr_o),
    .rd_ptr_o      (rd_ptr_o),
    .rd_gray_o     (rd_gray_o),
    .wr_ptr_sync_o (wr_ptr_sync_o),
    .empty_o       (empty_o),
    .level_o       (level_o),
    .gray_err_o    (gray_err_o),
    .underflow_o   (underflow_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [PW-1:0] rd_ptr;
    logic          empty;
    logic [PW-1:0] level;
    logic [PW-1:0] wsync;
    logic          gerr;
    logic          unf;
  } exp_t;

  typedef struct {
    logic [PW-1:0] wr_bin;
    logic          rd;
    exp_t          e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[18];

  logic [PW-1:0] m_sync0, m_sync1, m_prev, m_rd, m_level, m_wsync;
  logic          m_empty, m_gerr, m_unf;

  function automatic logic [PW-1:0] b2g(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] g2b(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic vec_t mk(input int wb, input int rd, input int p, input int em,
                              input int lv, input int ws, input int uf);
    vec_t v;
    v.wr_bin   = PW'(wb);
    v.rd       = rd[0];
    v.e.rd_ptr = PW'(p);
    v.e.empty  = em[0];
    v.e.level  = PW'(lv);
    v.e.wsync  = PW'(ws);
    v.e.gerr   = 1'b0;
    v.e.unf    = uf[0] & CHK;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_sync0 = '0; m_sync1 = '0; m_prev = '0; m_rd = '0;
    m_level = '0; m_wsync = '0; m_empty = 1'b1; m_gerr = 1'b0; m_unf = 1'b0;
  endtask

  // Reference behaviour for one read-clock edge, from pre-edge state.
  task automatic m_step(input logic [PW-1:0] g, input logic rd, output exp_t e);
    logic [PW-1:0] wb, nxt;
    wb  = g2b(m_sync1);
    nxt = m_rd + ((rd && !m_empty) ? PW'(1) : PW'(0));
    if (CHK) begin
      m_gerr = m_gerr | ($countones(m_sync1 ^ m_prev) > 1);
      m_unf  = m_unf | (rd & m_empty);
    end
    m_prev  = m_sync1;
    m_rd    = nxt;
    m_empty = (nxt == wb);
    m_level = wb - nxt;
    m_wsync = wb;
    m_sync1 = m_sync0;
    m_sync0 = g;
    e.rd_ptr = m_rd; e.empty = m_empty; e.level = m_level;
    e.wsync  = m_wsync; e.gerr = m_gerr; e.unf = m_unf;
  endtask

  task automatic compare(input exp_t e, input string tag);
    chk({tag, ".rd_ptr"},    32'(rd_ptr_o),      32'(e.rd_ptr));
    chk({tag, ".rd_gray"},   32'(rd_gray_o),     32'(b2g(e.rd_ptr)));
    chk({tag, ".rd_addr"},   32'(rd_addr_o),     32'(e.rd_ptr[AW-1:0]));
    chk({tag, ".empty"},     32'(empty_o),       32'(e.empty));
    chk({tag, ".level"},     32'(level_o),       32'(e.level));
    chk({tag, ".wr_sync"},   32'(wr_ptr_sync_o), 32'(e.wsync));
    chk({tag, ".gray_err"},  32'(gray_err_o),    32'(e.gerr));
    chk({tag, ".underflow"}, 32'(underflow_o),   32'(e.unf));
  endtask

  // Drive one cycle; the expectation is queued before the edge and checked after it.
  task automatic cyc(input logic [PW-1:0] g, input logic rd, input bit use_hand,
                     input exp_t he, input string tag);
    exp_t me, got;
    wr_gray_i = g;
    rd_en_i   = rd;
    m_step(g, rd, me);
    if (use_hand) sb_q.push_back(he);
    else          sb_q.push_back(me);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb_q.pop_front();
      compare(got, tag);
    end
  endtask

  task automatic mcyc(input logic [PW-1:0] g, input logic rd, input string tag);
    exp_t dummy;
    dummy = '{default: '0};
    cyc(g, rd, 1'b0, dummy, tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".rd_ptr"},    32'(rd_ptr_o),      32'd0);
    chk({tag, ".rd_gray"},   32'(rd_gray_o),     32'd0);
    chk({tag, ".rd_addr"},   32'(rd_addr_o),     32'd0);
    chk({tag, ".wr_sync"},   32'(wr_ptr_sync_o), 32'd0);
    chk({tag, ".empty"},     32'(empty_o),       32'd1);
    chk({tag, ".level"},     32'(level_o),       32'd0);
    chk({tag, ".gray_err"},  32'(gray_err_o),    32'd0);
    chk({tag, ".underflow"}, 32'(underflow_o),   32'd0);
  endtask

  // Asserts reset away from any clock edge and checks the outputs clear at once.
  task automatic do_reset(input string tag);
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_values(tag);
    wr_gray_i = '0;
    rd_en_i   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    m_reset();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin
    //            wb rd  ptr em lv ws uf
    tbl[0]  = mk(0, 0,  0, 1, 0, 0, 0);
    tbl[1]  = mk(1, 0,  0, 1, 0, 0, 0);
    tbl[2]  = mk(1, 0,  0, 1, 0, 0, 0);
    tbl[3]  = mk(1, 0,  0, 0, 1, 1, 0);
    tbl[4]  = mk(1, 1,  1, 1, 0, 1, 0);
    tbl[5]  = mk(1, 1,  1, 1, 0, 1, 1);
    tbl[6]  = mk(2, 0,  1, 1, 0, 1, 1);
    tbl[7]  = mk(3, 0,  1, 1, 0, 1, 1);
    tbl[8]  = mk(3, 0,  1, 0, 1, 2, 1);
    tbl[9]  = mk(3, 1,  2, 0, 1, 3, 1);
    tbl[10] = mk(3, 1,  3, 1, 0, 3, 1);
    tbl[11] = mk(3, 1,  3, 1, 0, 3, 1);
    tbl[12] = mk(4, 0,  3, 1, 0, 3, 1);
    tbl[13] = mk(5, 0,  3, 1, 0, 3, 1);
    tbl[14] = mk(5, 0,  3, 0, 1, 4, 1);
    tbl[15] = mk(5, 0,  3, 0, 2, 5, 1);
    tbl[16] = mk(5, 1,  4, 0, 1, 5, 1);
    tbl[17] = mk(5, 1,  5, 1, 0, 5, 1);

    reset_n   = 1'b0;
    wr_gray_i = '0;
    rd_en_i   = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("init");
    @(negedge clk);
    reset_n = 1'b1;

    // Single write, read, read-while-empty and simultaneous read/sync update.
    for (int i = 0; i < 18; i++) begin
      cyc(b2g(tbl[i].wr_bin), tbl[i].rd, 1'b1, tbl[i].e, $sformatf("vec%0d", i));
    end

    mcyc(b2g(5'd6), 1'b0, "pre_rst");
    mcyc(b2g(5'd6), 1'b0, "pre_rst");
    do_reset("mid_rst");
    mcyc('0, 1'b0, "post_rst");

    // Fill to full, then drain with surplus reads.
    for (int b = 0; b <= 16; b++) begin
      for (int k = 0; k < 4; k++) mcyc(b2g(PW'(b)), 1'b0, $sformatf("fill%0d", b));
    end
    chk("full.level", 32'(level_o), 32'd16);
    chk("full.empty", 32'(empty_o), 32'd0);
    for (int k = 0; k < 20; k++) mcyc(b2g(5'd16), 1'b1, $sformatf("drain%0d", k));
    chk("drained.rd_ptr", 32'(rd_ptr_o), 32'd16);
    chk("drained.level",  32'(level_o),  32'd0);
    chk("drained.empty",  32'(empty_o),  32'd1);

    // Pointer wrap from 31 to 0.
    for (int b = 17; b <= 31; b++) begin
      for (int k = 0; k < 4; k++) mcyc(b2g(PW'(b)), 1'b1, $sformatf("walk%0d", b));
    end
    for (int k = 0; k < 4; k++) mcyc(b2g(5'd31), 1'b1, "walk_tail");
    chk("pre_wrap.rd_ptr",  32'(rd_ptr_o),  32'd31);
    chk("pre_wrap.rd_gray", 32'(rd_gray_o), 32'h10);
    for (int k = 0; k < 2; k++) mcyc(b2g(5'd0), 1'b0, "wr_wrap0");
    for (int k = 0; k < 4; k++) mcyc(b2g(5'd1), 1'b0, "wr_wrap1");
    chk("pre_wrap.level", 32'(level_o), 32'd2);
    mcyc(b2g(5'd1), 1'b1, "wrap_read");
    chk("wrap.rd_ptr",  32'(rd_ptr_o),  32'd0);
    chk("wrap.rd_gray", 32'(rd_gray_o), 32'd0);
    chk("wrap.rd_addr", 32'(rd_addr_o), 32'd0);
    chk("wrap.level",   32'(level_o),   32'd1);
    chk("wrap.empty",   32'(empty_o),   32'd0);

    // Underflow on an empty FIFO.
    do_reset("rst_unf");
    mcyc('0, 1'b1, "unf_read");
    chk("unf.flag",   32'(underflow_o), 32'(CHK));
    chk("unf.rd_ptr", 32'(rd_ptr_o),    32'd0);

    // Illegal two-bit Gray step.
    do_reset("rst_gerr");
    mcyc(5'b00011, 1'b0, "gerr_k");
    mcyc(5'b00011, 1'b0, "gerr_k1");
    chk("gerr.k1", 32'(gray_err_o), 32'd0);
    mcyc(5'b00011, 1'b0, "gerr_k2");
    chk("gerr.k2", 32'(gray_err_o), 32'(CHK));
    for (int k = 0; k < 3; k++) mcyc(5'b00011, 1'b0, "gerr_hold");
    chk("gerr.sticky", 32'(gray_err_o), 32'(CHK));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_rd_ptr_sync.md
# fifo_rd_ptr_sync

Read-side pointer stage of the async FIFO, downstream of the binary-to-Gray converter in the write domain. Brings the write pointer's Gray code into the read clock domain through a multi-flop synchronizer and converts it back to binary. Maintains the local read pointer in binary and Gray, and produces registered empty and fill-level status.

## Interface
- ADDR_W, 4, FIFO address width; pointers are ADDR_W+1 bits (extra wrap bit)
- SYNC_STAGES, 2, synchronizer depth; legal range 2..4
- clk  input  1  read-domain clock
- reset_n  input  1  asynchronous, active-low reset
- wr_gray_i  input  ADDR_W+1  write pointer in Gray code; asynchronous to clk
- rd_en_i  input  1  read request for this cycle
- rd_addr_o  output  ADDR_W  RAM read address, equal to rd_ptr_o[ADDR_W-1:0]
- rd_ptr_o  output  ADDR_W+1  read pointer, binary
- rd_gray_o  output  ADDR_W+1  read pointer, Gray; returned to the write domain
- wr_ptr_sync_o  output  ADDR_W+1  synchronized write pointer, binary
- empty_o  output  1  FIFO empty
- level_o  output  ADDR_W+1  entries available, 0..2^ADDR_W
- gray_err_o  output  1  sticky error: synchronized Gray changed by more than one bit
- underflow_o  output  1  sticky flag: rd_en_i was high while empty_o was high

## Operation
- Synchronizer: wr_gray_i is sampled by SYNC_STAGES flops in series. Every stage resets to 0.
- Gray to binary on the last stage: b[ADDR_W] = g[ADDR_W]; b[i] = b[i+1] ^ g[i]. The result is registered into wr_ptr_sync_o.
- Read accept:
  - accept = rd_en_i && !empty_o.
  - rd_next = rd_ptr_o + accept, modulo 2^(ADDR_W+1). It wraps from 2^(ADDR_W+1)-1 to 0.
- On each clk edge, all registered:
  - rd_ptr_o <= rd_next
  - rd_gray_o <= (rd_next >> 1) ^ rd_next
  - empty_o <= (rd_next == wr_bin), where wr_bin is the conversion of the last sync stage
  - level_o <= (wr_bin - rd_next) mod 2^(ADDR_W+1)
- Simultaneous read and write-pointer update: both apply in the same edge, with no priority. The level follows the arithmetic above.
- A rd_en_i while empty is ignored: the pointer holds.
- Reset values: rd_ptr_o = 0, rd_gray_o = 0, rd_addr_o = 0, wr_ptr_sync_o = 0, empty_o = 1, level_o = 0, gray_err_o = 0, underflow_o = 0.
- Reset mid-operation: every flop clears immediately, including the synchronizer. Status is valid from the first clk edge after reset_n rises.
- No FSM. The state is the sync pipeline, the pointer register and the sticky flags.

## Timing
- Write-pointer latency: a wr_gray_i change sampled at edge k reaches the last sync stage at edge k+SYNC_STAGES-1. It is visible on empty_o, level_o and wr_ptr_sync_o at edge k+SYNC_STAGES (3 edges for the default).
- Read latency: rd_en_i accepted at edge k updates rd_ptr_o, rd_gray_o, empty_o and level_o at edge k itself. empty_o asserts on the same edge as the final read, so there is no read-past-empty window.
- All outputs are flop-driven. There are no combinational paths from inputs to outputs except rd_addr_o, which is a slice of rd_ptr_o.

## Configuration
- FIFO_PTR_CHK_EN defined:
  - The last sync stage's previous value is held. gray_err_o sets when the popcount of (current ^ previous) is greater than 1.
  - underflow_o sets on rd_en_i && empty_o.
  - Both flags are sticky until reset.
- Not defined: gray_err_o and underflow_o are tied to 0, the check logic is absent, and the ports remain.

## Structure
- Shared package fifo_ptr_pkg holds:
  - the bin2gray and gray2bin functions, parameterized by width through a width-generic function or a let expression;
  - the default ADDR_W constant.
- Sub-module sync_ndff(WIDTH, STAGES): a plain flop chain with asynchronous active-low reset, reused by the write-side pointer stage.

## Test plan
- Reset: assert reset_n=0 mid-traffic → all outputs are 0 except empty_o=1, with no clock edge needed. Release → empty_o=1 and level_o=0.
- Single write: wr_gray_i 00000→00001 → empty_o=0, level_o=1, wr_ptr_sync_o=1 exactly 3 edges later. One rd_en_i pulse → rd_ptr_o=1, rd_gray_o=00001, empty_o=1 on that edge.
- Fill and drain: walk wr_gray_i through bin 0..16 (Gray 11000), one step per 4 cycles → level_o reaches 16. Hold rd_en_i=1 for 20 cycles → level_o steps 16→0, rd_ptr_o stops at 16, extra reads are ignored.
- Wrap: preload traffic so rd_ptr_o=31 (Gray 10000) and the write pointer is at 1 → one read gives rd_ptr_o=0, rd_gray_o=00000, rd_addr_o=0, level_o=1.
- Simultaneous: read accepted on the same edge the sync stage advances the write pointer by one → level_o is unchanged and empty_o is unchanged.
- Checks (FIFO_PTR_CHK_EN): wr_gray_i 00000→00011 → gray_err_o=1 at edge k+2 and it stays. rd_en_i=1 while empty → underflow_o=1 and rd_ptr_o holds. Without the macro, both are 0.
